// File: rtl/dmem_stream_arbiter_if.sv
// Bundle of the CPU, image-stream and DataMemory signals around dmem_stream_arbiter.
// slave is the arbiter's view and master is the surrounding system's view.
interface dmem_stream_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wd;
    logic [31:0] cpu_rd;
    logic        cpu_stall;
    logic        start;
    logic [7:0]  strm_data;
    logic        strm_valid;
    logic        strm_ready;
    logic        busy;
    logic        done;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic        mem_we;
    logic [31:0] mem_rd;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wd, start, strm_ready, mem_rd,
        output cpu_rd, cpu_stall, strm_data, strm_valid, busy, done,
        output mem_addr, mem_wd, mem_we
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wd, start, strm_ready, mem_rd,
        input  cpu_rd, cpu_stall, strm_data, strm_valid, busy, done,
        input  mem_addr, mem_wd, mem_we
    );
endinterface

// File: rtl/dmem_stream_arbiter.sv
// Shares the DataMemory port between the CPU and a byte-wide image streamer (CPU first).
// Define STARVE_GUARD_EN to force a stream grant after MAX_WAIT consecutive denied fetch cycles.
module dmem_stream_arbiter #(
    parameter logic [31:0] IMG_BASE = 32'd0,
    parameter int          IMG_LEN  = 152100,
    parameter int          MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    dmem_stream_arbiter_if.slave  bus
);

    localparam int PTR_W = (IMG_LEN > 1) ? $clog2(IMG_LEN) : 1;
    localparam logic [PTR_W-1:0] LAST = PTR_W'(IMG_LEN - 1);

    if (IMG_LEN < 1 || MAX_WAIT < 0) begin : g_param_check
        $error("dmem_stream_arbiter: IMG_LEN must be >= 1 and MAX_WAIT >= 0");
    end

    typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

    state_t           state, state_next;
    logic [PTR_W-1:0] ptr, ptr_next;
    logic [7:0]       byte_p1, byte_next;
    logic             grant_stream;
    logic             forced;

`ifdef STARVE_GUARD_EN
    localparam int WAIT_W = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

    logic [WAIT_W-1:0] wait_cnt, wait_next;

    assign forced = (state == FETCH) && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_next;
        end
    end

    // Counts only denied FETCH cycles; any grant or leaving FETCH starts over.
    always_comb begin
        wait_next = '0;
        if (state == FETCH && !grant_stream) begin
            wait_next = wait_cnt + 1'b1;
        end
    end
`else
    assign forced = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ptr     <= '0;
            byte_p1 <= '0;
        end else begin
            state   <= state_next;
            ptr     <= ptr_next;
            byte_p1 <= byte_next;
        end
    end

    always_comb begin
        state_next   = state;
        ptr_next     = ptr;
        byte_next    = byte_p1;
        grant_stream = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_next = FETCH;
                    ptr_next   = '0;
                end
            end
            FETCH: begin
                grant_stream = !bus.cpu_req || forced;
                if (grant_stream) begin
                    byte_next  = bus.mem_rd[7:0];
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (bus.strm_ready) begin
                    if (ptr == LAST) begin
                        state_next = DONE;
                    end else begin
                        ptr_next   = ptr + 1'b1;
                        state_next = FETCH;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Port mux: the stream only reads, so a stream grant also masks any CPU store.
    always_comb begin
        bus.mem_addr = bus.cpu_addr;
        bus.mem_wd   = bus.cpu_wd;
        bus.mem_we   = bus.cpu_we & bus.cpu_req;
        if (grant_stream) begin
            bus.mem_addr = IMG_BASE + 32'(ptr);
            bus.mem_wd   = 32'h0;
            bus.mem_we   = 1'b0;
        end
    end

    assign bus.cpu_stall  = bus.cpu_req & grant_stream;
    assign bus.cpu_rd     = bus.mem_rd;
    assign bus.strm_data  = byte_p1;
    assign bus.strm_valid = (state == HOLD);
    assign bus.busy       = (state != IDLE);
    assign bus.done       = (state == DONE);

endmodule

// File: tb/tb_dmem_stream_arbiter.sv
// Directed bench for dmem_stream_arbiter with a byte scoreboard and a small DataMemory model.
// Runs in either build of STARVE_GUARD_EN.
module tb_dmem_stream_arbiter;

    localparam logic [31:0] IMG_BASE = 32'h0;
    localparam int          IMG_LEN  = 12;
    localparam int          MAX_WAIT = 15;
    localparam logic [31:0] FAR_ADDR = 32'd152100;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_stream_arbiter_if bus();

    dmem_stream_arbiter #(
        .IMG_BASE (IMG_BASE),
        .IMG_LEN  (IMG_LEN),
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] ram [0:1023];
    logic [31:0] far_word;
    logic [7:0]  sb [$];
    int          n_vec    = 0;
    int          n_err    = 0;
    int          done_cnt = 0;

    function automatic logic [7:0] img_byte(input int i);
        return 8'((i + 1) * 17);
    endfunction

    // Image region is read-only content; upper bits are junk the streamer must drop.
    always_comb begin
        if ((bus.mem_addr - IMG_BASE) < IMG_LEN)
            bus.mem_rd = {24'hA5C3E1, img_byte(int'(bus.mem_addr - IMG_BASE))};
        else if (bus.mem_addr == FAR_ADDR)
            bus.mem_rd = far_word;
        else if (bus.mem_addr < 32'd1024)
            bus.mem_rd = ram[bus.mem_addr[9:0]];
        else
            bus.mem_rd = 32'h0;
    end

    always @(posedge clk) begin
        if (bus.mem_we) begin
            if (bus.mem_addr == FAR_ADDR) far_word <= bus.mem_wd;
            else if (bus.mem_addr < 32'd1024) ram[bus.mem_addr[9:0]] <= bus.mem_wd;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Handshake monitor, sampled just before the edge that completes the transfer.
    always @(negedge clk) begin
        #2;
        if (bus.done === 1'b1) done_cnt++;
        if (bus.strm_valid === 1'b1 && bus.strm_ready === 1'b1) begin
            n_vec++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL sb_unexpected: observed byte %0h expected none", bus.strm_data);
            end
            if (sb.size() != 0) chk("strm_byte", 32'(bus.strm_data), 32'(sb.pop_front()));
        end
    end

    task automatic push_frame();
        for (int i = 0; i < IMG_LEN; i++) sb.push_back(img_byte(i));
    endtask

    task automatic wait_done(input string tag, input int limit);
        int k = 0;
        while (bus.done !== 1'b1 && k < limit) begin
            @(negedge clk); #1;
            k++;
        end
        chk(tag, 32'(bus.done), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dc;
        int seen;
        int k;

        rst = 1'b1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h40; bus.cpu_wd = 32'h12345678;
        bus.start = 1'b0; bus.strm_ready = 1'b1;

        // Reset state: stream idle, CPU owns the port.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_valid", 32'(bus.strm_valid), 32'd0);
        chk("rst_busy",  32'(bus.busy), 32'd0);
        chk("rst_done",  32'(bus.done), 32'd0);
        chk("rst_data",  32'(bus.strm_data), 32'd0);
        chk("rst_addr",  bus.mem_addr, 32'h40);
        chk("rst_wd",    bus.mem_wd, 32'h12345678);
        chk("rst_we",    32'(bus.mem_we), 32'd1);
        chk("rst_stall", 32'(bus.cpu_stall), 32'd0);
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
        rst = 1'b0;

        // Frame 1: free port, ready high.
        @(negedge clk);
        bus.start = 1'b1; push_frame();
        #1 chk("f1_idle_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("f1_fetch_addr",  bus.mem_addr, IMG_BASE);
        chk("f1_fetch_we",    32'(bus.mem_we), 32'd0);
        chk("f1_fetch_wd",    bus.mem_wd, 32'd0);
        chk("f1_fetch_valid", 32'(bus.strm_valid), 32'd0);
        chk("f1_busy",        32'(bus.busy), 32'd1);
        @(negedge clk); #1;
        chk("f1_valid0", 32'(bus.strm_valid), 32'd1);
        chk("f1_data0",  32'(bus.strm_data), 32'h11);
        chk("f1_hold_addr", bus.mem_addr, 32'h40);
        @(negedge clk); #1;
        chk("f1_fetch1_addr", bus.mem_addr, IMG_BASE + 32'd1);
        chk("f1_fetch1_valid", 32'(bus.strm_valid), 32'd0);
        @(negedge clk); #1;
        chk("f1_data1", 32'(bus.strm_data), 32'h22);
        wait_done("f1_done_seen", 40);
        @(negedge clk); #1;
        chk("f1_done_low", 32'(bus.done), 32'd0);
        chk("f1_busy_low", 32'(bus.busy), 32'd0);
        chk("f1_done_cnt", 32'(done_cnt), 32'd1);
        chk("f1_sb_empty", 32'(sb.size()), 32'd0);

        // Frame 2: back-pressure in HOLD with CPU stores, then CPU stalls the fetch.
        @(negedge clk);
        bus.start = 1'b1; bus.strm_ready = 1'b0; push_frame();
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
            bus.cpu_addr = 32'h200 + 32'(i); bus.cpu_wd = 32'hC0DE0000 + 32'(i);
            #1;
            chk("bp_valid", 32'(bus.strm_valid), 32'd1);
            chk("bp_data",  32'(bus.strm_data), 32'h11);
            chk("bp_we",    32'(bus.mem_we), 32'd1);
            chk("bp_addr",  bus.mem_addr, 32'h200 + 32'(i));
            chk("bp_stall", 32'(bus.cpu_stall), 32'd0);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.strm_ready = 1'b1;
        #1;
        chk("bp_release_valid", 32'(bus.strm_valid), 32'd1);
        chk("bp_release_we",    32'(bus.mem_we), 32'd0);
        chk("bp_stored",        ram[10'h204], 32'hC0DE0004);
        @(negedge clk);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = FAR_ADDR; bus.cpu_wd = 32'hDEADBEEF;
        #1;
        chk("st_stall", 32'(bus.cpu_stall), 32'd0);
        chk("st_we",    32'(bus.mem_we), 32'd1);
        chk("st_addr",  bus.mem_addr, FAR_ADDR);
        chk("st_wd",    bus.mem_wd, 32'hDEADBEEF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("st_fetch_stalled", 32'(bus.strm_valid), 32'd0);
        end
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
        #1;
        chk("st_strm_addr", bus.mem_addr, IMG_BASE + 32'd1);
        chk("st_far_word",  far_word, 32'hDEADBEEF);
        @(negedge clk); #1;
        chk("st_valid1", 32'(bus.strm_valid), 32'd1);
        chk("st_data1",  32'(bus.strm_data), 32'h22);
        wait_done("f2_done_seen", 60);
        @(negedge clk); #1;
        chk("f2_done_cnt", 32'(done_cnt), 32'd2);
        chk("f2_sb_empty", 32'(sb.size()), 32'd0);

        // Frame 3: CPU hammers the port for the whole fetch.
        @(negedge clk);
        bus.start = 1'b1; push_frame();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1;
        bus.cpu_addr = 32'h300; bus.cpu_wd = 32'h5A5A0000;
`ifdef STARVE_GUARD_EN
        for (int i = 1; i <= MAX_WAIT + 1; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            if (i <= MAX_WAIT) begin
                chk("sg_deny_valid", 32'(bus.strm_valid), 32'd0);
                chk("sg_deny_stall", 32'(bus.cpu_stall), 32'd0);
                chk("sg_deny_we",    32'(bus.mem_we), 32'd1);
            end else begin
                chk("sg_force_stall", 32'(bus.cpu_stall), 32'd1);
                chk("sg_force_we",    32'(bus.mem_we), 32'd0);
                chk("sg_force_addr",  bus.mem_addr, IMG_BASE);
            end
        end
        @(negedge clk); #1;
        chk("sg_after_valid", 32'(bus.strm_valid), 32'd1);
        chk("sg_after_data",  32'(bus.strm_data), 32'h11);
        chk("sg_after_stall", 32'(bus.cpu_stall), 32'd0);
        chk("sg_after_we",    32'(bus.mem_we), 32'd1);
`else
        for (int i = 1; i <= MAX_WAIT + 5; i++) begin
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            chk("nf_deny_valid", 32'(bus.strm_valid), 32'd0);
            chk("nf_deny_stall", 32'(bus.cpu_stall), 32'd0);
            chk("nf_deny_we",    32'(bus.mem_we), 32'd1);
        end
`endif
        @(negedge clk);
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = 32'h40;
        wait_done("f3_done_seen", 60);
        @(negedge clk); #1;
        chk("f3_done_cnt", 32'(done_cnt), 32'd3);
        chk("f3_sb_empty", 32'(sb.size()), 32'd0);

        // Frame 4: reset while holding byte 7.
        @(negedge clk);
        bus.start = 1'b1; push_frame();
        @(negedge clk);
        bus.start = 1'b0;
        seen = 0; k = 0;
        while (seen < 8 && k < 50) begin
            @(negedge clk); #1;
            k++;
            if (bus.strm_valid === 1'b1) begin
                seen++;
                if (seen == 8) bus.strm_ready = 1'b0;
            end
        end
        chk("rh_reached_ptr7", 32'(seen), 32'd8);
        chk("rh_data7", 32'(bus.strm_data), 32'(img_byte(7)));
        #1 rst = 1'b1;
        #1;
        chk("rh_valid", 32'(bus.strm_valid), 32'd0);
        chk("rh_busy",  32'(bus.busy), 32'd0);
        chk("rh_done",  32'(bus.done), 32'd0);
        sb.delete();
        dc = done_cnt;
        @(negedge clk);
        rst = 1'b0; bus.strm_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rh_no_done", 32'(done_cnt), 32'(dc));
        chk("rh_idle",    32'(bus.busy), 32'd0);

        // Frame 5: restart from the base, with a stray start mid-frame.
        @(negedge clk);
        bus.start = 1'b1; push_frame();
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        chk("rs_addr",  bus.mem_addr, IMG_BASE);
        chk("rs_valid", 32'(bus.strm_valid), 32'd0);
        @(negedge clk); #1;
        chk("rs_data0", 32'(bus.strm_data), 32'h11);
        repeat (4) @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        #1 chk("sw_busy", 32'(bus.busy), 32'd1);
        @(negedge clk);
        bus.start = 1'b0;
        wait_done("f5_done_seen", 60);
        repeat (6) @(negedge clk);
        #1;
        chk("f5_done_cnt", 32'(done_cnt), 32'(dc + 1));
        chk("f5_idle",     32'(bus.busy), 32'd0);
        chk("f5_sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
